alu_op_sequencer: RTL and testbench



---
 rtl/alu_pkg.sv | 29 ++
 rtl/alu_op_decode.sv | 26 ++
 rtl/alu_op_sequencer.sv | 137 +++++++++++++
 tb/tb_alu_op_sequencer.sv | 238 +++++++++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// Shared definitions for the ALU operation sequencer and its decoder:
// opcode values, FSM state encoding, select bit positions and default width.
package alu_pkg;

    localparam int WIDTH_DEF = 8;

    // Instruction opcodes; 6 and 7 are illegal
    localparam logic [2:0] OP_AND = 3'd0;
    localparam logic [2:0] OP_OR  = 3'd1;
    localparam logic [2:0] OP_NOT = 3'd2;
    localparam logic [2:0] OP_XOR = 3'd3;
    localparam logic [2:0] OP_ADD = 3'd4;
    localparam logic [2:0] OP_MOV = 3'd5;

    // Sequencer states
    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_EXEC = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

    // Bit positions inside the one-hot select vector (aop..fop)
    localparam int NUM_SEL = 6;
    localparam int SEL_AND = 0;
    localparam int SEL_OR  = 1;
    localparam int SEL_NOT = 2;
    localparam int SEL_XOR = 3;
    localparam int SEL_SUM = 4;
    localparam int SEL_REG = 5;

endpackage

// File: rtl/alu_op_decode.sv
// Combinational opcode decoder: 3-bit opcode to one-hot result-mux selects
// plus an illegal-opcode flag. Kept standalone so fetch/decode logic can reuse it.
module alu_op_decode
    import alu_pkg::*;
(
    input  logic [2:0]         opcode_i,
    output logic [NUM_SEL-1:0] sel_o,
    output logic               illegal_o
);

    // One select per legal opcode; anything else flags illegal with no select
    always_comb begin
        sel_o     = '0;
        illegal_o = 1'b0;
        case (opcode_i)
            OP_AND:  sel_o[SEL_AND] = 1'b1;
            OP_OR:   sel_o[SEL_OR]  = 1'b1;
            OP_NOT:  sel_o[SEL_NOT] = 1'b1;
            OP_XOR:  sel_o[SEL_XOR] = 1'b1;
            OP_ADD:  sel_o[SEL_SUM] = 1'b1;
            OP_MOV:  sel_o[SEL_REG] = 1'b1;
            default: illegal_o      = 1'b1;
        endcase
    end

endmodule

// File: rtl/alu_op_sequencer.sv
// Control and accumulator stage in front of the ALU result mux.
// IDLE accepts an instruction, EXEC drives one registered select while the
// mux result is captured into the accumulator, DONE pulses done. One
// instruction retires every three cycles.
module alu_op_sequencer
    import alu_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEF,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             instr_valid,
    output logic             instr_ready,
    input  logic [2:0]       opcode,
    input  logic [WIDTH-1:0] operand,
    output logic [WIDTH-1:0] src_a,
    output logic [WIDTH-1:0] src_b,
    output logic             aop,
    output logic             bop,
    output logic             cop,
    output logic             dop,
    output logic             eop,
    output logic             fop,
    input  logic [WIDTH-1:0] res,
    input  logic             carry_in,
    output logic [WIDTH-1:0] acc,
    output logic             zero_flag,
    output logic             carry_flag,
    output logic             done,
    output logic             err,
    output logic [CNT_W-1:0] instr_count
);

    logic [1:0]         state_q, state_d;
    logic [2:0]         op_q, op_d;
    logic [WIDTH-1:0]   src_b_q, src_b_d;
    logic [NUM_SEL-1:0] sel_q, sel_d;
    logic [WIDTH-1:0]   acc_q, acc_d;
    logic               zero_q, zero_d;
    logic               carry_q, carry_d;
    logic               err_q, err_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;

    logic [NUM_SEL-1:0] dec_sel;
    logic               dec_illegal;

    alu_op_decode u_decode (
        .opcode_i  (opcode),
        .sel_o     (dec_sel),
        .illegal_o (dec_illegal)
    );

    // Next-state logic: accept in IDLE, capture the mux result in EXEC, retire in DONE.
    // Selects are loaded from the decoder on accept so they are registered
    // (glitch-free) during EXEC and default back to zero everywhere else.
    always_comb begin
        state_d = state_q;
        op_d    = op_q;
        src_b_d = src_b_q;
        sel_d   = '0;
        acc_d   = acc_q;
        zero_d  = zero_q;
        carry_d = carry_q;
        err_d   = 1'b0;
        cnt_d   = cnt_q;
        case (state_q)
            ST_IDLE: begin
                if (instr_valid) begin
                    if (dec_illegal) begin
                        err_d = 1'b1;
                    end else begin
                        op_d    = opcode;
                        src_b_d = operand;
                        sel_d   = dec_sel;
                        state_d = ST_EXEC;
                    end
                end
            end
            ST_EXEC: begin
                acc_d   = res;
                zero_d  = (res == '0);
                carry_d = (op_q == OP_ADD) ? carry_in : 1'b0;
                cnt_d   = cnt_q + CNT_W'(1);
                state_d = ST_DONE;
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State, accumulator, flags and counter; reset aborts any instruction in flight
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            op_q    <= OP_AND;
            src_b_q <= '0;
            sel_q   <= '0;
            acc_q   <= '0;
            zero_q  <= 1'b0;
            carry_q <= 1'b0;
            err_q   <= 1'b0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            op_q    <= op_d;
            src_b_q <= src_b_d;
            sel_q   <= sel_d;
            acc_q   <= acc_d;
            zero_q  <= zero_d;
            carry_q <= carry_d;
            err_q   <= err_d;
            cnt_q   <= cnt_d;
        end
    end

    assign instr_ready = (state_q == ST_IDLE);
    assign done        = (state_q == ST_DONE);
    assign src_a       = acc_q;
    assign src_b       = src_b_q;
    assign aop         = sel_q[SEL_AND];
    assign bop         = sel_q[SEL_OR];
    assign cop         = sel_q[SEL_NOT];
    assign dop         = sel_q[SEL_XOR];
    assign eop         = sel_q[SEL_SUM];
    assign fop         = sel_q[SEL_REG];
    assign acc         = acc_q;
    assign zero_flag   = zero_q;
    assign carry_flag  = carry_q;
    assign err         = err_q;
    assign instr_count = cnt_q;

endmodule

// File: tb/tb_alu_op_sequencer.sv
// Bench for alu_op_sequencer: plays the ALU units and result mux around the
// DUT and compares against a behavioural accumulator model.
module tb_alu_op_sequencer;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        instr_valid;
    logic        instr_ready;
    logic [2:0]  opcode;
    logic [7:0]  operand;
    logic [7:0]  src_a, src_b, res, acc;
    logic        aop, bop, cop, dop, eop, fop;
    logic        carry_in, zero_flag, carry_flag, done, err;
    logic [15:0] instr_count;

    logic [5:0]  sel;
    logic [8:0]  sum_ab;

    int          checks = 0;
    int          errors = 0;
    int          oh_bad = 0;

    logic [7:0]  acc_m;
    logic        zf_m, cf_m;
    logic [15:0] cnt_m;

    alu_op_sequencer #(.WIDTH(8), .CNT_W(16)) dut (
        .clk(clk), .rst_n(rst_n), .instr_valid(instr_valid), .instr_ready(instr_ready),
        .opcode(opcode), .operand(operand), .src_a(src_a), .src_b(src_b),
        .aop(aop), .bop(bop), .cop(cop), .dop(dop), .eop(eop), .fop(fop),
        .res(res), .carry_in(carry_in), .acc(acc), .zero_flag(zero_flag),
        .carry_flag(carry_flag), .done(done), .err(err), .instr_count(instr_count)
    );

    always #5 clk = ~clk;

    // Environment: the ALU units and the combinational result mux
    assign sel    = {fop, eop, dop, cop, bop, aop};
    assign sum_ab = {1'b0, src_a} + {1'b0, src_b};
    assign carry_in = sum_ab[8];
    always_comb begin
        res = 8'hA5;
        if (aop)      res = src_a & src_b;
        else if (bop) res = src_a | src_b;
        else if (cop) res = ~src_a;
        else if (dop) res = src_a ^ src_b;
        else if (eop) res = sum_ab[7:0];
        else if (fop) res = src_b;
    end

    // Selects must never be multi-hot
    always @(negedge clk) begin
        if (rst_n === 1'b1 && !$onehot0(sel)) begin
            $display("FAIL onehot sel=%b at %0t", sel, $time);
            oh_bad = oh_bad + 1;
        end
    end

    // Reference: {carry, result} of one instruction from the opcode table
    function automatic logic [8:0] ref_op(input logic [2:0] op, input logic [7:0] a, input logic [7:0] b);
        case (op)
            3'd0:    return {1'b0, a & b};
            3'd1:    return {1'b0, a | b};
            3'd2:    return {1'b0, ~a};
            3'd3:    return {1'b0, a ^ b};
            3'd4:    return {1'b0, a} + {1'b0, b};
            3'd5:    return {1'b0, b};
            default: return {1'b0, a};
        endcase
    endfunction

    // Issue one instruction starting at a negedge in IDLE; ends at a negedge back in IDLE
    task automatic run_instr(input logic [2:0] op, input logic [7:0] opd, input string tag);
        logic [8:0] r;
        logic [5:0] exp_sel;
        int w;
        w = 0;
        while (instr_ready !== 1'b1 && w < 10) begin
            @(negedge clk);
            w++;
        end
        checks++; if (instr_ready !== 1'b1) begin errors++; $display("FAIL %s ready_wait got %b want 1", tag, instr_ready); end
        instr_valid = 1'b1; opcode = op; operand = opd;
        @(negedge clk);
        if (op >= 3'd6) begin
            checks++; if (err !== 1'b1) begin errors++; $display("FAIL %s err_pulse got %b want 1", tag, err); end
            checks++; if (instr_ready !== 1'b1) begin errors++; $display("FAIL %s ill_ready got %b want 1", tag, instr_ready); end
            checks++; if (sel !== 6'b0) begin errors++; $display("FAIL %s ill_sel got %b want 000000", tag, sel); end
            checks++; if (acc !== acc_m || zero_flag !== zf_m || carry_flag !== cf_m) begin errors++;
                $display("FAIL %s ill_state got %h/%b/%b want %h/%b/%b", tag, acc, zero_flag, carry_flag, acc_m, zf_m, cf_m); end
            checks++; if (instr_count !== cnt_m) begin errors++; $display("FAIL %s ill_count got %0d want %0d", tag, instr_count, cnt_m); end
            instr_valid = 1'b0; operand = 8'($urandom);
            @(negedge clk);
            checks++; if (err !== 1'b0) begin errors++; $display("FAIL %s err_one_cycle got %b want 0", tag, err); end
            return;
        end
        exp_sel = 6'b000001 << op;
        checks++; if (sel !== exp_sel) begin errors++; $display("FAIL %s exec_sel got %b want %b", tag, sel, exp_sel); end
        checks++; if (instr_ready !== 1'b0 || done !== 1'b0) begin errors++; $display("FAIL %s exec_ctl got rdy=%b done=%b want 0 0", tag, instr_ready, done); end
        checks++; if (src_b !== opd || src_a !== acc_m) begin errors++; $display("FAIL %s exec_src got a=%h b=%h want a=%h b=%h", tag, src_a, src_b, acc_m, opd); end
        instr_valid = 1'b0; opcode = 3'($urandom); operand = 8'($urandom);
        r = ref_op(op, acc_m, opd);
        acc_m = r[7:0];
        zf_m  = (r[7:0] == 8'h00);
        cf_m  = (op == 3'd4) ? r[8] : 1'b0;
        cnt_m = cnt_m + 16'd1;
        @(negedge clk);
        checks++; if (done !== 1'b1) begin errors++; $display("FAIL %s done_pulse got %b want 1", tag, done); end
        checks++; if (acc !== acc_m || zero_flag !== zf_m || carry_flag !== cf_m) begin errors++;
            $display("FAIL %s result got %h/%b/%b want %h/%b/%b", tag, acc, zero_flag, carry_flag, acc_m, zf_m, cf_m); end
        checks++; if (sel !== 6'b0 || instr_ready !== 1'b0) begin errors++; $display("FAIL %s done_ctl got sel=%b rdy=%b want 0 0", tag, sel, instr_ready); end
        @(negedge clk);
        checks++; if (done !== 1'b0 || instr_ready !== 1'b1) begin errors++; $display("FAIL %s idle_ctl got done=%b rdy=%b want 0 1", tag, done, instr_ready); end
        checks++; if (instr_count !== cnt_m) begin errors++; $display("FAIL %s count got %0d want %0d", tag, instr_count, cnt_m); end
    endtask

    task automatic test_reset();
        rst_n = 1'b0; instr_valid = 1'b0; opcode = 3'd0; operand = 8'h00;
        acc_m = 8'h00; zf_m = 1'b0; cf_m = 1'b0; cnt_m = 16'd0;
        repeat (3) @(negedge clk);
        checks++; if (acc !== 8'h00 || zero_flag !== 1'b0 || carry_flag !== 1'b0) begin errors++;
            $display("FAIL reset_data got %h/%b/%b want 00/0/0", acc, zero_flag, carry_flag); end
        checks++; if (src_b !== 8'h00 || sel !== 6'b0 || done !== 1'b0 || err !== 1'b0) begin errors++;
            $display("FAIL reset_ctl got b=%h sel=%b done=%b err=%b want 00 000000 0 0", src_b, sel, done, err); end
        checks++; if (instr_count !== 16'd0 || instr_ready !== 1'b1) begin errors++;
            $display("FAIL reset_cnt got cnt=%0d rdy=%b want 0 1", instr_count, instr_ready); end
        rst_n = 1'b1;
        @(negedge clk);
        checks++; if (instr_ready !== 1'b1 || acc !== 8'h00) begin errors++; $display("FAIL reset_release got rdy=%b acc=%h want 1 00", instr_ready, acc); end
    endtask

    task automatic test_mov();
        run_instr(3'd5, 8'h5A, "mov");
        checks++; if (acc !== 8'h5A || instr_count !== 16'd1) begin errors++; $display("FAIL mov_final got acc=%h cnt=%0d want 5a 1", acc, instr_count); end
    endtask

    task automatic test_and_zero();
        run_instr(3'd5, 8'hF0, "and_setup");
        run_instr(3'd0, 8'h0F, "and");
        checks++; if (acc !== 8'h00 || zero_flag !== 1'b1 || carry_flag !== 1'b0) begin errors++;
            $display("FAIL and_final got %h/%b/%b want 00/1/0", acc, zero_flag, carry_flag); end
    endtask

    task automatic test_add_carry();
        run_instr(3'd5, 8'hFF, "add_setup");
        run_instr(3'd4, 8'h01, "add");
        checks++; if (acc !== 8'h00 || zero_flag !== 1'b1 || carry_flag !== 1'b1) begin errors++;
            $display("FAIL add_final got %h/%b/%b want 00/1/1", acc, zero_flag, carry_flag); end
        run_instr(3'd3, 8'h3C, "xor_after_add");
        checks++; if (acc !== 8'h3C || zero_flag !== 1'b0 || carry_flag !== 1'b0) begin errors++;
            $display("FAIL xor_final got %h/%b/%b want 3c/0/0", acc, zero_flag, carry_flag); end
    endtask

    task automatic test_illegal();
        run_instr(3'd7, 8'h99, "illegal7");
        run_instr(3'd6, 8'h42, "illegal6");
        checks++; if (acc !== 8'h3C || instr_count !== cnt_m) begin errors++; $display("FAIL illegal_final got acc=%h cnt=%0d want 3c %0d", acc, instr_count, cnt_m); end
    endtask

    task automatic test_back_to_back();
        logic [2:0]  ops [3] = '{3'd1, 3'd4, 3'd5};
        logic [7:0]  opds[3] = '{8'h81, 8'h90, 8'h07};
        logic [15:0] cnt0;
        logic [8:0]  r;
        cnt0 = cnt_m;
        for (int i = 0; i < 3; i++) begin
            checks++; if (instr_ready !== 1'b1) begin errors++; $display("FAIL b2b_ready%0d got %b want 1", i, instr_ready); end
            instr_valid = 1'b1; opcode = ops[i]; operand = opds[i];
            @(negedge clk);
            checks++; if (instr_ready !== 1'b0 || src_b !== opds[i]) begin errors++; $display("FAIL b2b_exec%0d got rdy=%b b=%h want 0 %h", i, instr_ready, src_b, opds[i]); end
            opcode = 3'd7; operand = 8'($urandom);
            r = ref_op(ops[i], acc_m, opds[i]);
            acc_m = r[7:0]; zf_m = (r[7:0] == 8'h00); cf_m = (ops[i] == 3'd4) ? r[8] : 1'b0; cnt_m = cnt_m + 16'd1;
            @(negedge clk);
            checks++; if (done !== 1'b1 || instr_ready !== 1'b0 || src_b !== opds[i] || err !== 1'b0) begin errors++;
                $display("FAIL b2b_done%0d got done=%b rdy=%b b=%h err=%b want 1 0 %h 0", i, done, instr_ready, src_b, err, opds[i]); end
            checks++; if (acc !== acc_m || carry_flag !== cf_m || zero_flag !== zf_m) begin errors++;
                $display("FAIL b2b_acc%0d got %h/%b/%b want %h/%b/%b", i, acc, zero_flag, carry_flag, acc_m, zf_m, cf_m); end
            @(negedge clk);
        end
        instr_valid = 1'b0;
        checks++; if (instr_count !== cnt0 + 16'd3 || err !== 1'b0 || instr_ready !== 1'b1) begin errors++;
            $display("FAIL b2b_count got cnt=%0d err=%b rdy=%b want %0d 0 1", instr_count, err, instr_ready, cnt0 + 16'd3); end
    endtask

    task automatic test_random();
        for (int i = 0; i < 40; i++) begin
            run_instr(3'($urandom_range(0, 7)), 8'($urandom), "random");
            if ($urandom_range(0, 3) == 0) @(negedge clk);
        end
    endtask

    task automatic test_reset_mid_exec();
        run_instr(3'd5, 8'h22, "mid_setup");
        instr_valid = 1'b1; opcode = 3'd4; operand = 8'h33;
        @(negedge clk);
        checks++; if (eop !== 1'b1) begin errors++; $display("FAIL mid_exec_eop got %b want 1", eop); end
        instr_valid = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        checks++; if (acc !== 8'h00 || zero_flag !== 1'b0 || carry_flag !== 1'b0 || src_b !== 8'h00) begin errors++;
            $display("FAIL mid_reset_data got acc=%h z=%b c=%b b=%h want 00 0 0 00", acc, zero_flag, carry_flag, src_b); end
        checks++; if (sel !== 6'b0 || done !== 1'b0 || err !== 1'b0 || instr_ready !== 1'b1 || instr_count !== 16'd0) begin errors++;
            $display("FAIL mid_reset_ctl got sel=%b done=%b err=%b rdy=%b cnt=%0d want 0 0 0 1 0", sel, done, err, instr_ready, instr_count); end
        acc_m = 8'h00; zf_m = 1'b0; cf_m = 1'b0; cnt_m = 16'd0;
        @(negedge clk);
        checks++; if (done !== 1'b0 || acc !== 8'h00) begin errors++; $display("FAIL mid_no_done got done=%b acc=%h want 0 00", done, acc); end
        rst_n = 1'b1;
        @(negedge clk);
        run_instr(3'd5, 8'h11, "after_reset_mov");
        checks++; if (acc !== 8'h11 || instr_count !== 16'd1) begin errors++; $display("FAIL after_reset got acc=%h cnt=%0d want 11 1", acc, instr_count); end
    endtask

    task automatic test_onehot();
        checks++; if (oh_bad !== 0) begin errors++; $display("FAIL onehot_total got %0d want 0", oh_bad); end
    endtask

    initial begin
        test_reset();
        test_mov();
        test_and_zero();
        test_add_carry();
        test_illegal();
        test_back_to_back();
        test_random();
        test_reset_mid_exec();
        test_onehot();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog expired at %0t", $time);
        $fatal(1, "watchdog");
    end

endmodule
